// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, opcode encodings, buffered-entry layout and snoop rule
package alu_pkg;

  localparam int DATA_W = 16;
  localparam int RA_W   = 3;
  localparam int OP_W   = 4;
  localparam int IMM_W  = 5;

  typedef enum logic [OP_W-1:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    AND  = 4'd2,
    OR   = 4'd3,
    XOR  = 4'd4,
    NOT  = 4'd5,
    CLR  = 4'd6,
    CMPE = 4'd7,
    CMPG = 4'd8,
    CMPL = 4'd9,
    SHRA = 4'd10,
    SHRL = 4'd11,
    SHL  = 4'd12
  } alu_op_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_e;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [RA_W-1:0]   dst;
    logic [RA_W-1:0]   src_a;
    logic [RA_W-1:0]   src_b;
    logic              imm_sel;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  function automatic logic [DATA_W-1:0] zext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){1'b0}}, imm};
  endfunction

  // Writeback overwrite of a held entry; immediate-sourced B is never touched.
  function automatic entry_t snoop(input entry_t e, input logic live, input logic we,
                                   input logic [RA_W-1:0] dst, input logic [DATA_W-1:0] data);
    entry_t r;
    r = e;
    if (live && we) begin
      if (e.src_a == dst) r.a = data;
      if (!e.imm_sel && e.src_b == dst) r.b = data;
    end
    return r;
  endfunction

endpackage

// File: rtl/operand_entry.sv
// rtl/operand_entry.sv - one buffered issue entry that tracks writebacks while held
module operand_entry
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               live,
  input  logic               load,
  input  logic [ENTRY_W-1:0] load_data,
  input  logic               wb_we,
  input  logic [RA_W-1:0]    wb_dst,
  input  logic [DATA_W-1:0]  wb_data,
  output logic [ENTRY_W-1:0] q
);

  entry_t q_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= '0;
    end else if (load) begin
      q_r <= entry_t'(load_data);
    end else begin
      q_r <= snoop(q_r, live, wb_we, wb_dst, wb_data);
    end
  end

  assign q = q_r;

endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - operand select, writeback bypass and two-entry skid buffer ahead of the ALU
module alu_operand_stage
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [RA_W-1:0]   in_dst,
  input  logic [RA_W-1:0]   in_src_a,
  input  logic [RA_W-1:0]   in_src_b,
  input  logic [DATA_W-1:0] in_rdata_a,
  input  logic [DATA_W-1:0] in_rdata_b,
  input  logic              in_imm_sel,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic              wb_we,
  input  logic [RA_W-1:0]   wb_dst,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [OP_W-1:0]   out_op,
  output logic [RA_W-1:0]   out_dst
);

  stage_state_e state, state_nxt;
  logic   push, pop;
  logic   head_load, skid_load, head_from_skid;
  entry_t cap, head_q, skid_q, skid_fwd, head_d;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    cap         = '0;
    cap.op      = in_op;
    cap.dst     = in_dst;
    cap.src_a   = in_src_a;
    cap.src_b   = in_src_b;
    cap.imm_sel = in_imm_sel;
    cap.a       = (wb_we && wb_dst == in_src_a) ? wb_data : in_rdata_a;
    if (in_imm_sel)
      cap.b = zext_imm(in_imm);
    else
      cap.b = (wb_we && wb_dst == in_src_b) ? wb_data : in_rdata_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    head_load      = 1'b0;
    skid_load      = 1'b0;
    head_from_skid = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (push) begin
          state_nxt = ONE;
          head_load = 1'b1;
        end
        ONE: begin
          if (push && pop) begin
            head_load = 1'b1;
          end else if (push) begin
            state_nxt = TWO;
            skid_load = 1'b1;
          end else if (pop) begin
            state_nxt = EMPTY;
          end
        end
        TWO: if (pop) begin
          state_nxt      = ONE;
          head_load      = 1'b1;
          head_from_skid = 1'b1;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // The skid entry hands over with this cycle's writeback already applied.
  assign skid_fwd = snoop(skid_q, state == TWO, wb_we, wb_dst, wb_data);
  assign head_d   = head_from_skid ? skid_fwd : cap;

  operand_entry u_head (
    .clk       (clk),
    .rst_n     (rst_n),
    .live      (state != EMPTY),
    .load      (head_load),
    .load_data (head_d),
    .wb_we     (wb_we),
    .wb_dst    (wb_dst),
    .wb_data   (wb_data),
    .q         (head_q)
  );

  operand_entry u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .live      (state == TWO),
    .load      (skid_load),
    .load_data (cap),
    .wb_we     (wb_we),
    .wb_dst    (wb_dst),
    .wb_data   (wb_data),
    .q         (skid_q)
  );

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign out_a     = head_q.a;
  assign out_b     = head_q.b;
  assign out_op    = head_q.op;
  assign out_dst   = head_q.dst;

  logic unused_head_tags;
  assign unused_head_tags = ^{head_q.src_a, head_q.src_b, head_q.imm_sel};

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - randomized and directed checks of alu_operand_stage against a queue model
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = '0;
  logic [2:0]  in_dst = '0, in_src_a = '0, in_src_b = '0;
  logic [15:0] in_rdata_a = '0, in_rdata_b = '0;
  logic        in_imm_sel = 1'b0;
  logic [4:0]  in_imm = '0;
  logic        wb_we = 1'b0;
  logic [2:0]  wb_dst = '0;
  logic [15:0] wb_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_a, out_b;
  logic [3:0]  out_op;
  logic [2:0]  out_dst;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  dst, sa, sb;
    logic        isel;
    logic [15:0] a, b;
  } m_entry_t;

  m_entry_t q[$];

  alu_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_dst(in_dst), .in_src_a(in_src_a), .in_src_b(in_src_b),
    .in_rdata_a(in_rdata_a), .in_rdata_b(in_rdata_b),
    .in_imm_sel(in_imm_sel), .in_imm(in_imm),
    .wb_we(wb_we), .wb_dst(wb_dst), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_op(out_op), .out_dst(out_dst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // What one clock edge does to the set of in-flight instructions.
  task automatic model_edge();
    bit do_push, do_pop;
    m_entry_t n;
    if (!rst_n || flush) begin
      q.delete();
      return;
    end
    do_push = in_valid && (q.size() < 2);
    do_pop  = (q.size() > 0) && out_ready;
    foreach (q[i]) begin
      if (wb_we && q[i].sa == wb_dst) q[i].a = wb_data;
      if (wb_we && !q[i].isel && q[i].sb == wb_dst) q[i].b = wb_data;
    end
    if (do_pop) void'(q.pop_front());
    if (do_push) begin
      n.op = in_op; n.dst = in_dst; n.sa = in_src_a; n.sb = in_src_b; n.isel = in_imm_sel;
      n.a = (wb_we && wb_dst == in_src_a) ? wb_data : in_rdata_a;
      if (in_imm_sel) n.b = {11'd0, in_imm};
      else n.b = (wb_we && wb_dst == in_src_b) ? wb_data : in_rdata_b;
      q.push_back(n);
    end
  endtask

  task automatic compare();
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
    if (q.size() > 0) begin
      chk("out_a", {16'd0, out_a}, {16'd0, q[0].a});
      chk("out_b", {16'd0, out_b}, {16'd0, q[0].b});
      chk("out_op", {28'd0, out_op}, {28'd0, q[0].op});
      chk("out_dst", {29'd0, out_dst}, {29'd0, q[0].dst});
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic set_in(input logic v, input logic [3:0] op, input logic [2:0] sa, input logic [2:0] sb,
                        input logic [15:0] ra, input logic [15:0] rb, input logic isel, input logic [4:0] imm);
    in_valid = v; in_op = op; in_dst = op[2:0]; in_src_a = sa; in_src_b = sb;
    in_rdata_a = ra; in_rdata_b = rb; in_imm_sel = isel; in_imm = imm;
  endtask

  initial begin
    repeat (2) cycle();
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst out_a", {16'd0, out_a}, 32'd0);
    chk("rst out_b", {16'd0, out_b}, 32'd0);
    chk("rst out_op", {28'd0, out_op}, 32'd0);
    chk("rst out_dst", {29'd0, out_dst}, 32'd0);
    rst_n = 1'b1;

    // single issue
    out_ready = 1'b1;
    set_in(1'b1, 4'd0, 3'd1, 3'd2, 16'h0005, 16'h0003, 1'b0, 5'd0);
    cycle();
    chk("issue out_valid", {31'd0, out_valid}, 32'd1);
    chk("issue out_a", {16'd0, out_a}, 32'h0005);
    chk("issue out_b", {16'd0, out_b}, 32'h0003);
    chk("issue out_op", {28'd0, out_op}, 32'd0);
    chk("issue in_ready", {31'd0, in_ready}, 32'd1);

    // immediate select is zero-extended and ignores rdata_b
    set_in(1'b1, 4'd12, 3'd1, 3'd2, 16'h0001, 16'hBEEF, 1'b1, 5'h1F);
    cycle();
    chk("imm out_b", {16'd0, out_b}, 32'h001F);
    chk("imm out_op", {28'd0, out_op}, 32'd12);

    // capture bypass, then snoop while stalled
    set_in(1'b1, 4'd4, 3'd3, 3'd3, 16'hAAAA, 16'hBBBB, 1'b1, 5'd7);
    wb_we = 1'b1; wb_dst = 3'd3; wb_data = 16'h1234;
    cycle();
    chk("bypass out_a", {16'd0, out_a}, 32'h1234);
    in_valid = 1'b0; out_ready = 1'b0; wb_data = 16'h5678;
    cycle();
    chk("snoop out_a", {16'd0, out_a}, 32'h5678);
    chk("snoop imm b", {16'd0, out_b}, 32'h0007);
    wb_we = 1'b0; out_ready = 1'b1;
    cycle();
    chk("drain empty", {31'd0, out_valid}, 32'd0);

    // backpressure into the skid, then ordered drain with overlapped push
    out_ready = 1'b0;
    set_in(1'b1, 4'd1, 3'd4, 3'd5, 16'h1111, 16'h0101, 1'b0, 5'd0);
    cycle();
    set_in(1'b1, 4'd2, 3'd4, 3'd5, 16'h2222, 16'h0202, 1'b0, 5'd0);
    cycle();
    chk("skid in_ready", {31'd0, in_ready}, 32'd0);
    chk("skid hold a", {16'd0, out_a}, 32'h1111);
    set_in(1'b1, 4'd9, 3'd4, 3'd5, 16'h9999, 16'h0909, 1'b0, 5'd0);
    cycle();
    chk("full hold op", {28'd0, out_op}, 32'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    chk("E2 out_a", {16'd0, out_a}, 32'h2222);
    chk("E2 in_ready", {31'd0, in_ready}, 32'd1);
    set_in(1'b1, 4'd3, 3'd4, 3'd5, 16'h3333, 16'h0303, 1'b0, 5'd0);
    cycle();
    chk("E3 out_a", {16'd0, out_a}, 32'h3333);
    in_valid = 1'b0;
    cycle();
    chk("E3 drained", {31'd0, out_valid}, 32'd0);

    // flush beats simultaneous push and pop
    out_ready = 1'b0;
    set_in(1'b1, 4'd14, 3'd1, 3'd1, 16'h4444, 16'h0404, 1'b0, 5'd0);
    cycle();
    set_in(1'b1, 4'd15, 3'd1, 3'd1, 16'h5555, 16'h0505, 1'b0, 5'd0);
    cycle();
    flush = 1'b1; out_ready = 1'b1;
    set_in(1'b1, 4'd13, 3'd1, 3'd1, 16'h6666, 16'h0606, 1'b0, 5'd0);
    cycle();
    chk("flush out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush in_ready", {31'd0, in_ready}, 32'd1);
    flush = 1'b0; in_valid = 1'b0;
    cycle();
    chk("flush no capture", {31'd0, out_valid}, 32'd0);

    // randomized traffic with heavy register aliasing
    for (int n = 0; n < 3000; n++) begin
      set_in($urandom_range(9, 0) < 7, 4'($urandom), 3'($urandom), 3'($urandom),
             16'($urandom), 16'($urandom), $urandom_range(9, 0) < 3, 5'($urandom));
      in_dst     = 3'($urandom);
      out_ready  = $urandom_range(9, 0) < 6;
      wb_we      = $urandom_range(1, 0) == 1;
      wb_dst     = 3'($urandom);
      wb_data    = 16'($urandom);
      flush      = $urandom_range(39, 0) == 0;
      cycle();
    end

    // async reset between edges while full
    flush = 1'b0; wb_we = 1'b0; out_ready = 1'b0;
    set_in(1'b1, 4'd7, 3'd2, 3'd6, 16'hF00D, 16'hCAFE, 1'b0, 5'd0);
    cycle();
    cycle();
    chk("pre-reset full", {31'd0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    chk("async out_valid", {31'd0, out_valid}, 32'd0);
    chk("async in_ready", {31'd0, in_ready}, 32'd1);
    chk("async out_a", {16'd0, out_a}, 32'd0);
    chk("async out_b", {16'd0, out_b}, 32'd0);
    in_valid = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
